// File: rtl/tweet_ram_sched_pkg.sv
// Shared constants and FSM state type for the tweet RAM scheduler.
package tweet_ram_sched_pkg;

  localparam int         DEPTH     = 256;
  localparam int         MAX_CHARS = 160;
  localparam logic [7:0] BS_CODE   = 8'h08;
  localparam int         VALID_BIT = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

  // Stored word: valid flag on top, character in the low byte.
  function automatic logic [15:0] char_word(input logic [7:0] c);
    return {1'b1, 7'b0, c};
  endfunction

endpackage

// File: rtl/tweet_ram_sched_if.sv
// Request/playback/RAM signal bundle between the serial front end, the scheduler and the RAM.
interface tweet_ram_sched_if;

  logic        clr_start;
  logic        clr_busy;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        wr_drop;
  logic        rd_start;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        rd_done;
  logic [7:0]  char_count;
  logic        full;
  logic        ram_write;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  modport slave (
    input  clr_start, wr_req, wr_data, rd_start, rd_ready, ram_dout,
    output clr_busy, wr_ack, wr_drop, rd_valid, rd_data, rd_done,
           char_count, full, ram_write, ram_addr, ram_din
  );

  modport master (
    output clr_start, wr_req, wr_data, rd_start, rd_ready, ram_dout,
    input  clr_busy, wr_ack, wr_drop, rd_valid, rd_data, rd_done,
           char_count, full, ram_write, ram_addr, ram_din
  );

endinterface

// File: rtl/tweet_ram_sched.sv
// Sole owner of the 256x16 tweet RAM: bulk clear > rx byte write/backspace > playback read.
// state   | meaning
// IDLE    | arbitrate clear / write / playback start
// CLEAR   | sweep zeros over every word
// RD_ADDR | end-of-text check, present playback address
// RD_WAIT | RAM word arrives, latch character
// RD_HOLD | character offered to the transmitter
module tweet_ram_sched
  import tweet_ram_sched_pkg::*;
(
  input logic sysclk,
  input logic reset,
  tweet_ram_sched_if.slave bus
);

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
  localparam logic [7:0] MAX_COUNT = 8'(MAX_CHARS);

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  char_count;
  logic [7:0]  rd_data_q;
  logic [7:0]  ram_addr_q;
  logic [15:0] ram_din_q;
  logic        init_pend;
  logic        clr_busy_q, wr_ack_q, wr_drop_q, rd_valid_q, rd_done_q, ram_write_q;
  logic        full, is_bs, clr_go, wr_take, do_write;

  assign full    = (char_count == MAX_COUNT);
  assign is_bs   = (bus.wr_data == BS_CODE);
  assign clr_go  = bus.clr_start || (state == IDLE && init_pend);
  // A request still high in the ack cycle is the one just consumed.
  assign wr_take  = bus.wr_req && !wr_ack_q;
  assign do_write = !clr_go && wr_take &&
                    (state == IDLE || (state == RD_HOLD && !bus.rd_ready));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      char_count  <= '0;
      init_pend   <= 1'b1;
      clr_busy_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_drop_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      ram_write_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_drop_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      if (clr_go) begin
        state       <= CLEAR;
        init_pend   <= 1'b0;
        cnt         <= '0;
        clr_busy_q  <= 1'b1;
        rd_valid_q  <= 1'b0;
        ram_write_q <= 1'b1;
        ram_addr_q  <= '0;
        ram_din_q   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!wr_take && bus.rd_start) begin
              cnt        <= '0;
              ram_addr_q <= '0;
              state      <= RD_ADDR;
            end
          end
          CLEAR: begin
            if (cnt == LAST_ADDR) begin
              char_count <= '0;
              clr_busy_q <= 1'b0;
              ram_addr_q <= '0;
              state      <= IDLE;
            end else begin
              cnt         <= cnt + 8'd1;
              ram_addr_q  <= cnt + 8'd1;
              ram_write_q <= 1'b1;
            end
          end
          RD_ADDR: begin
            if (cnt >= char_count) begin
              rd_done_q <= 1'b1;
              state     <= IDLE;
            end else begin
              ram_addr_q <= cnt;
              state      <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            rd_data_q <= bus.ram_dout[7:0];
            if (!bus.ram_dout[VALID_BIT]) begin
              rd_done_q <= 1'b1;
              state     <= IDLE;
            end else begin
              rd_valid_q <= 1'b1;
              state      <= RD_HOLD;
            end
          end
          RD_HOLD: begin
            // Next address goes out now so the registered RAM has it ready by RD_WAIT.
            if (bus.rd_ready) begin
              rd_valid_q <= 1'b0;
              cnt        <= cnt + 8'd1;
              ram_addr_q <= cnt + 8'd1;
              state      <= RD_ADDR;
            end
          end
          default: state <= IDLE;
        endcase

        if (do_write) begin
          wr_ack_q <= 1'b1;
          if (!is_bs && !full) begin
            ram_write_q <= 1'b1;
            ram_addr_q  <= char_count;
            ram_din_q   <= char_word(bus.wr_data);
            char_count  <= char_count + 8'd1;
          end else if (is_bs && char_count != 8'd0) begin
            ram_write_q <= 1'b1;
            ram_addr_q  <= char_count - 8'd1;
            ram_din_q   <= '0;
            char_count  <= char_count - 8'd1;
          end else begin
            wr_drop_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.clr_busy   = clr_busy_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.wr_drop    = wr_drop_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_done    = rd_done_q;
  assign bus.char_count = char_count;
  assign bus.full       = full;
  assign bus.ram_write  = ram_write_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;

endmodule

// File: tb/tb_tweet_ram_sched.sv
// Bench for tweet_ram_sched: directed scenarios plus random traffic, scored every cycle
// against a queue model of the stored text and the clear/playback rules.
module tb_tweet_ram_sched;
  import tweet_ram_sched_pkg::*;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int checks   = 0;
  int failures = 0;

  tweet_ram_sched_if bus();

  tweet_ram_sched dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  // Registered single-port RAM, read-old-data.
  logic [15:0] mem [256];
  always @(posedge sysclk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  logic [7:0]  text [$];
  int          sweep_idx, rd_idx, gap;
  bit          prev_busy, prev_clr, prev_valid, prev_ready, armed;
  logic [7:0]  prev_data;
  logic [7:0]  mb, exp_a;
  logic [15:0] exp_d;
  bit          exp_w, exp_drop;

  always @(negedge sysclk) begin
    if (reset) begin
      text.delete();
      sweep_idx = 0; rd_idx = 0; gap = 0; armed = 0;
      prev_busy = 0; prev_clr = 0; prev_valid = 0; prev_ready = 0; prev_data = '0;
    end else begin
      if (armed) gap++;

      if (prev_clr) begin
        chk("clr_start_reaction", bus.clr_busy && bus.ram_addr == 8'h00 && !bus.rd_valid && !bus.rd_done,
            {bus.clr_busy, bus.rd_valid, bus.rd_done, bus.ram_addr}, {1'b1, 1'b0, 1'b0, 8'h00});
        sweep_idx = 0;
        armed = 0;
      end else if (bus.clr_busy && !prev_busy) begin
        sweep_idx = 0;
      end
      if (bus.clr_busy) begin
        chk("clear_word", bus.ram_write && bus.ram_din == 16'h0 && bus.ram_addr == 8'(sweep_idx),
            {bus.ram_write, bus.ram_din, bus.ram_addr}, {1'b1, 16'h0, 8'(sweep_idx)});
        sweep_idx++;
      end else if (prev_busy) begin
        chk("clear_length", sweep_idx == DEPTH, sweep_idx, DEPTH);
        text.delete();
      end

      if (bus.wr_ack) begin
        mb = bus.wr_data;
        exp_w = 0; exp_drop = 0; exp_a = '0; exp_d = '0;
        if (mb == BS_CODE) begin
          if (text.size() > 0) begin
            exp_w = 1; exp_a = 8'(text.size() - 1);
            void'(text.pop_back());
          end else exp_drop = 1;
        end else if (text.size() < MAX_CHARS) begin
          exp_w = 1; exp_a = 8'(text.size()); exp_d = {8'h80, mb};
          text.push_back(mb);
        end else exp_drop = 1;
        chk("wr_drop", bus.wr_drop == exp_drop, bus.wr_drop, exp_drop);
        chk("wr_ram_port", bus.ram_write == exp_w && (!exp_w || (bus.ram_addr == exp_a && bus.ram_din == exp_d)),
            {bus.ram_write, bus.ram_addr, bus.ram_din}, {exp_w, exp_a, exp_d});
        chk("ack_with_done", !bus.rd_done, bus.rd_done, 0);
      end else if (!bus.clr_busy) begin
        chk("quiet_ram_port", !bus.ram_write && !bus.wr_drop, {bus.ram_write, bus.wr_drop}, 0);
      end

      chk("char_count", bus.char_count == 8'(text.size()) && bus.full == (text.size() == MAX_CHARS),
          {bus.full, bus.char_count}, {text.size() == MAX_CHARS, 8'(text.size())});

      if (bus.rd_start) rd_idx = 0;
      if (armed && bus.rd_valid && !prev_valid) begin
        chk("rd_latency", gap == 3, gap, 3);
        armed = 0;
      end
      if (prev_valid && !prev_ready && !prev_clr)
        chk("rd_hold_stable", bus.rd_valid && bus.rd_data == prev_data,
            {bus.rd_valid, bus.rd_data}, {1'b1, prev_data});
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_idx < text.size())
          chk("rd_char", bus.rd_data == text[rd_idx], bus.rd_data, text[rd_idx]);
        else
          chk("rd_char_extra", 1'b0, rd_idx, text.size());
        rd_idx++;
        armed = 1;
        gap = 0;
      end
      if (bus.rd_done) begin
        chk("rd_done_count", rd_idx == text.size() && !bus.rd_valid, rd_idx, text.size());
        armed = 0;
      end

      prev_busy  = bus.clr_busy;
      prev_clr   = bus.clr_start;
      prev_valid = bus.rd_valid;
      prev_ready = bus.rd_ready;
      prev_data  = bus.rd_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] got [$];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b, output bit dropped);
    int n;
    tick();
    bus.wr_req  = 1'b1;
    bus.wr_data = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.wr_ack && n < 1000);
    chk("wr_ack_seen", bus.wr_ack, bus.wr_ack, 1);
    dropped    = bus.wr_drop;
    bus.wr_req = 1'b0;
  endtask

  task automatic pulse_clr();
    tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
  endtask

  task automatic wait_clear(output int cyc, output bit saw_done);
    cyc = 0;
    saw_done = 0;
    while (bus.clr_busy && cyc < 600) begin
      cyc++;
      tick();
      if (bus.rd_done) saw_done = 1;
    end
    chk("clear_finished", !bus.clr_busy, bus.clr_busy, 0);
  endtask

  task automatic playback(input int pct, output bit done);
    int n;
    got.delete();
    done = 0;
    tick();
    bus.rd_start = 1'b1;
    bus.rd_ready = ($urandom_range(0, 99) < pct);
    tick();
    bus.rd_start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge sysclk);
      if (bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
      if (bus.rd_done) done = 1;
      tick();
      bus.rd_ready = ($urandom_range(0, 99) < pct);
      n++;
    end
    bus.rd_ready = 1'b0;
    chk("playback_done", done, done, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ctrl"}, {bus.clr_busy, bus.wr_ack, bus.wr_drop, bus.rd_valid, bus.rd_done, bus.full,
                          bus.ram_write, bus.rd_data, bus.char_count} == '0,
        {bus.clr_busy, bus.wr_ack, bus.wr_drop, bus.rd_valid, bus.rd_done, bus.full,
         bus.ram_write, bus.rd_data, bus.char_count}, 0);
    chk({name, "_ram"}, {bus.ram_addr, bus.ram_din} == '0, {bus.ram_addr, bus.ram_din}, 0);
  endtask

  initial begin
    #900000;
    failures++;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc, drops;
    bit done, dropped, saw_done;
    logic [7:0] d0, cc0;

    bus.clr_start = 0; bus.wr_req = 0; bus.wr_data = '0; bus.rd_start = 0; bus.rd_ready = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;

    repeat (3) tick();
    check_reset_outputs("reset_values");
    reset = 1'b0;
    tick();
    chk("auto_clear_start", bus.clr_busy, bus.clr_busy, 1);
    wait_clear(cyc, saw_done);
    chk("auto_clear_cycles", cyc == 256, cyc, 256);
    chk("post_clear_mem", mem[0] == 16'h0 && mem[100] == 16'h0 && mem[255] == 16'h0,
        {mem[0], mem[255]}, 0);
    chk("post_clear_count", bus.char_count == 8'd0, bus.char_count, 0);

    // 'H','i', then backspace
    do_write(8'h48, dropped);
    do_write(8'h69, dropped);
    tick();
    chk("ram_H", mem[0] == 16'h8048, mem[0], 16'h8048);
    chk("ram_i", mem[1] == 16'h8069, mem[1], 16'h8069);
    chk("count_Hi", bus.char_count == 8'd2, bus.char_count, 2);
    do_write(8'h08, dropped);
    tick();
    chk("bs_erases", mem[1] == 16'h0 && !dropped, {dropped, mem[1]}, 0);
    chk("count_after_bs", bus.char_count == 8'd1, bus.char_count, 1);

    do_write(8'h61, dropped);
    do_write(8'h62, dropped);
    playback(100, done);
    chk("playback_Hab_len", got.size() == 3, got.size(), 3);
    if (got.size() == 3)
      chk("playback_Hab", {got[0], got[1], got[2]} == 24'h486162, {got[0], got[1], got[2]}, 24'h486162);

    pulse_clr();
    wait_clear(cyc, saw_done);
    playback(100, done);
    chk("empty_playback", got.size() == 0 && done, got.size(), 0);
    do_write(BS_CODE, dropped);
    chk("bs_at_zero_drop", dropped, dropped, 1);

    // fill past the limit
    drops = 0;
    for (int i = 0; i < 161; i++) begin
      do_write(8'($urandom_range(32, 126)), dropped);
      if (dropped) drops++;
      if (i == 160) chk("byte161_dropped", dropped, dropped, 1);
    end
    chk("fill_drop_count", drops == 1, drops, 1);
    chk("full_flag", bus.full && bus.char_count == 8'd160, {bus.full, bus.char_count}, {1'b1, 8'd160});
    playback(60, done);
    chk("full_playback_len", got.size() == 160, got.size(), 160);

    // write serviced while a character is held, then abort by clear
    pulse_clr();
    wait_clear(cyc, saw_done);
    do_write(8'h41, dropped);
    do_write(8'h42, dropped);
    tick();
    bus.rd_ready = 1'b0;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    cyc = 0;
    while (!bus.rd_valid && cyc < 20) begin tick(); cyc++; end
    chk("hold_valid", bus.rd_valid && bus.rd_data == 8'h41, {bus.rd_valid, bus.rd_data}, {1'b1, 8'h41});
    d0 = bus.rd_data;
    cc0 = bus.char_count;
    do_write(8'h5A, dropped);
    chk("hold_write_stored", !dropped && bus.char_count == cc0 + 8'd1, bus.char_count, cc0 + 8'd1);
    chk("hold_data_kept", bus.rd_valid && bus.rd_data == d0, {bus.rd_valid, bus.rd_data}, {1'b1, d0});
    tick();
    chk("hold_write_ram", mem[2] == 16'h805A, mem[2], 16'h805A);
    pulse_clr();
    chk("abort_drops_valid", !bus.rd_valid && bus.clr_busy, {bus.rd_valid, bus.clr_busy}, 2'b01);
    wait_clear(cyc, saw_done);
    chk("abort_no_done", !saw_done, saw_done, 0);
    chk("abort_clear_cycles", cyc == 256, cyc, 256);

    // random traffic
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        if ($urandom_range(0, 99) < 15) do_write(BS_CODE, dropped);
        else do_write(8'($urandom_range(32, 126)), dropped);
      end else if (op <= 8) begin
        fork
          playback($urandom_range(30, 100), done);
          begin
            repeat ($urandom_range(3, 12)) tick();
            do_write(8'($urandom_range(32, 126)), dropped);
          end
        join
      end else begin
        pulse_clr();
        wait_clear(cyc, saw_done);
      end
    end
    repeat (2) tick();
    for (int i = 0; i < text.size(); i++)
      chk("ram_content", mem[i] == {8'h80, text[i]}, mem[i], {8'h80, text[i]});

    // reset in the middle of playback
    do_write(8'h51, dropped);
    tick();
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("midop_reset");
    reset = 1'b0;
    tick();
    chk("midop_auto_clear", bus.clr_busy, bus.clr_busy, 1);
    wait_clear(cyc, saw_done);
    chk("midop_clear_cycles", cyc == 256, cyc, 256);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
